// File: rtl/fifo_ptr_pkg.sv
// Shared FIFO pointer definitions: default widths, write-side FSM states and the
// full-detect helper used by both the write and read pointer controllers.
package fifo_ptr_pkg;

    localparam int unsigned FIFO_ADDR_W = 8;
    localparam int unsigned FIFO_STAT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PKT     = 2'd1,
        ST_DISCARD = 2'd2
    } wp_state_t;

    // Full when the slot after wp is rp (one slot kept unused); aw must be < 32.
    function automatic logic ptr_full(input logic [31:0] wp, input logic [31:0] rp,
                                      input int unsigned aw);
        logic [31:0] mask;
        mask = (32'd1 << aw) - 32'd1;
        return (((wp + 32'd1) ^ rp) & mask) == 32'd0;
    endfunction

endpackage

// File: rtl/fifo_wp_stats.sv
// Saturating packet/drop counter pair for the FIFO write-pointer controller.
module fifo_wp_stats
    import fifo_ptr_pkg::*;
#(
    parameter int unsigned STAT_W = FIFO_STAT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_inc,
    input  logic              drop_inc,
    output logic [STAT_W-1:0] pkt_cnt,
    output logic [STAT_W-1:0] drop_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (pkt_inc && (pkt_cnt != '1))
                pkt_cnt <= pkt_cnt + STAT_W'(1);
            if (drop_inc && (drop_cnt != '1))
                drop_cnt <= drop_cnt + STAT_W'(1);
        end
    end

endmodule

// File: rtl/fifo_wp_ctrl.sv
// Packet FIFO write-pointer controller: speculative WP, WP_commit published on eop,
// rollback on drop/overflow. Optional stats counters under FIFO_WP_STATS_EN.
module fifo_wp_ctrl
    import fifo_ptr_pkg::*;
#(
    parameter int unsigned ADDR_W = FIFO_ADDR_W
`ifdef FIFO_WP_STATS_EN
    ,
    parameter int unsigned STAT_W = FIFO_STAT_W
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_sop,
    input  logic              wr_eop,
    input  logic              drop,
    input  logic [ADDR_W-1:0] RP,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] WP,
    output logic [ADDR_W-1:0] WP_commit,
    output logic              FIFO_FULL,
    output logic              pkt_drop,
    output logic              proto_err
`ifdef FIFO_WP_STATS_EN
    ,
    output logic [STAT_W-1:0] pkt_cnt,
    output logic [STAT_W-1:0] drop_cnt
`endif
);

    wp_state_t state;
    logic      full;
    logic      accept;
    logic      commit;

    assign full      = ptr_full(32'(WP), 32'(RP), ADDR_W);
    assign FIFO_FULL = full;
    assign mem_addr  = WP;

    always_comb begin
        accept = 1'b0;
        case (state)
            ST_IDLE: accept = wr_en & wr_sop & ~full;
            ST_PKT:  accept = wr_en & ~drop & ~wr_sop & ~full;
            default: accept = 1'b0;
        endcase
    end

    // A word presented during reset is never written.
    assign mem_we = accept & ~rst;
    assign commit = accept & wr_eop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            WP        <= '0;
            WP_commit <= '0;
            pkt_drop  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            pkt_drop  <= 1'b0;
            proto_err <= 1'b0;
            if (accept)
                WP <= WP + ADDR_W'(1);
            if (commit)
                WP_commit <= WP + ADDR_W'(1);
            case (state)
                ST_IDLE: begin
                    if (wr_en) begin
                        if (!wr_sop) begin
                            proto_err <= 1'b1;
                        end else if (full) begin
                            pkt_drop <= 1'b1;
                            state    <= wr_eop ? ST_IDLE : ST_DISCARD;
                        end else if (!wr_eop) begin
                            state <= ST_PKT;
                        end
                    end
                end
                ST_PKT: begin
                    // drop, nested sop and overflow all abort the packet the same way
                    if (drop || (wr_en && (wr_sop || full))) begin
                        WP       <= WP_commit;
                        pkt_drop <= 1'b1;
                        state    <= (wr_en && wr_eop) ? ST_IDLE : ST_DISCARD;
                    end else if (wr_en && wr_eop) begin
                        state <= ST_IDLE;
                    end
                end
                ST_DISCARD: begin
                    if (wr_en && wr_eop)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef FIFO_WP_STATS_EN
    fifo_wp_stats #(
        .STAT_W(STAT_W)
    ) u_stats (
        .clk     (clk),
        .rst     (rst),
        .pkt_inc (commit),
        .drop_inc(pkt_drop),
        .pkt_cnt (pkt_cnt),
        .drop_cnt(drop_cnt)
    );
`endif

endmodule
